// File: rtl/dc_axi_avalon_rd_bridge.sv
// AXI4 read-only slave bridging the display controller's AR/R channels onto an
// Avalon-MM pipelined burst read port. Response-FIFO credit for a whole burst
// is reserved before the Avalon request goes out, because readdatavalid cannot
// be back-pressured. Responses are returned strictly in AR acceptance order.
module dc_axi_avalon_rd_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int ID_WIDTH        = 8,
    parameter int FIFO_DEPTH      = 256,
    parameter int FIFO_ADDR_WIDTH = 8,
    parameter int CMD_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   axi_arid,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic [1:0]            axi_arlock,
    input  logic [3:0]            axi_arcache,
    input  logic [2:0]            axi_arprot,
    input  logic [3:0]            axi_arqos,
    input  logic [3:0]            axi_arregion,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [ID_WIDTH-1:0]   axi_rid,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [8:0]            avm_burstcount,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int CW     = FIFO_ADDR_WIDTH + 1;

    localparam logic [2:0]      SIZE_C   = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0]      INCR_C   = 2'b01;
    localparam logic [CMD_AW:0] CMD_INC  = (CMD_AW + 1)'(1);
    localparam logic [CMD_AW:0] CMD_FULL = (CMD_AW + 1)'(CMD_DEPTH);
    localparam logic [CW-1:0]   CW_ONE   = CW'(1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t state_q, state_d;

    logic                  arready_q, arready_d;
    logic [CMD_AW:0]       cmd_wr_q, cmd_wr_d;
    logic [CMD_AW:0]       cmd_rd_q, cmd_rd_d;
    logic [CMD_AW:0]       cmd_iss_q, cmd_iss_d;
    logic [ADDR_WIDTH-1:0] avm_addr_q, avm_addr_d;
    logic [8:0]            avm_bc_q, avm_bc_d;
    logic [CW-1:0]         reserved_q, reserved_d;
    logic [CW-1:0]         data_wr_q, data_wr_d;
    logic [CW-1:0]         data_rd_q, data_rd_d;
    logic [7:0]            beat_q, beat_d;

    logic [ID_WIDTH-1:0]   cmd_id_q   [CMD_DEPTH];
    logic [7:0]            cmd_len_q  [CMD_DEPTH];
    logic                  cmd_err_q  [CMD_DEPTH];
    logic [ADDR_WIDTH-1:1] cmd_addr_q [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];

    logic            ar_push, ar_err;
    logic [CMD_AW:0] cmd_count, cmd_count_next;
    logic            cmd_empty;
    logic            iss_pending, iss_adv, reserve;
    logic [CW-1:0]   iss_beats, credit_free;
    logic            head_err, data_empty, rvalid, r_fire, r_last_beat;
    logic            cmd_pop, data_push, data_pop;
    logic            unused_ok;

    assign unused_ok = ^{axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                         axi_arregion, axi_araddr[0]};

    assign ar_push   = arready_q & axi_arvalid;
    assign ar_err    = (axi_arsize != SIZE_C) || (axi_arburst != INCR_C);
    assign cmd_count = cmd_wr_q - cmd_rd_q;
    assign cmd_empty = (cmd_wr_q == cmd_rd_q);

    assign iss_pending = (cmd_iss_q != cmd_wr_q);
    assign iss_beats   = CW'({1'b0, cmd_len_q[cmd_iss_q[CMD_AW-1:0]]}) + CW_ONE;
    assign credit_free = DEPTH_C - reserved_q;

    assign head_err    = cmd_err_q[cmd_rd_q[CMD_AW-1:0]];
    assign data_empty  = (data_wr_q == data_rd_q);
    assign rvalid      = !cmd_empty && (head_err || !data_empty);
    assign r_fire      = rvalid && axi_rready;
    assign r_last_beat = (beat_q == cmd_len_q[cmd_rd_q[CMD_AW-1:0]]);
    assign cmd_pop     = r_fire && r_last_beat;
    assign data_pop    = r_fire && !head_err;
    // Data arriving with no live command is stale traffic from before a reset.
    assign data_push   = avm_readdatavalid && !cmd_empty;

    // Issue FSM: walk unissued commands in order, skipping err ones, and only
    // launch a burst once the response FIFO has room for all of its beats.
    always_comb begin
        state_d    = state_q;
        iss_adv    = 1'b0;
        reserve    = 1'b0;
        avm_addr_d = avm_addr_q;
        avm_bc_d   = avm_bc_q;
        case (state_q)
            S_IDLE: begin
                if (iss_pending) begin
                    if (cmd_err_q[cmd_iss_q[CMD_AW-1:0]]) begin
                        iss_adv = 1'b1;
                    end else if (credit_free >= iss_beats) begin
                        state_d    = S_ISSUE;
                        iss_adv    = 1'b1;
                        reserve    = 1'b1;
                        avm_addr_d = {cmd_addr_q[cmd_iss_q[CMD_AW-1:0]], 1'b0};
                        avm_bc_d   = 9'({1'b0, cmd_len_q[cmd_iss_q[CMD_AW-1:0]]}) + 9'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (!avm_waitrequest) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue pointers, credit, R beat counter and the registered arready.
    always_comb begin
        cmd_wr_d       = cmd_wr_q + (ar_push ? CMD_INC : '0);
        cmd_rd_d       = cmd_rd_q + (cmd_pop ? CMD_INC : '0);
        cmd_iss_d      = cmd_iss_q + (iss_adv ? CMD_INC : '0);
        data_wr_d      = data_wr_q + (data_push ? CW_ONE : '0);
        data_rd_d      = data_rd_q + (data_pop ? CW_ONE : '0);
        reserved_d     = reserved_q + (reserve ? iss_beats : '0) - (data_pop ? CW_ONE : '0);
        beat_d         = beat_q;
        if (cmd_pop) begin
            beat_d = '0;
        end else if (r_fire) begin
            beat_d = beat_q + 8'd1;
        end
        // Judged on next-cycle occupancy so a push this cycle cannot overfill.
        cmd_count_next = cmd_count + (ar_push ? CMD_INC : '0) - (cmd_pop ? CMD_INC : '0);
        arready_d      = (cmd_count_next < CMD_FULL) && (state_d == S_IDLE);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            arready_q  <= 1'b0;
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_iss_q  <= '0;
            avm_addr_q <= '0;
            avm_bc_q   <= '0;
            reserved_q <= '0;
            data_wr_q  <= '0;
            data_rd_q  <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_iss_q  <= cmd_iss_d;
            avm_addr_q <= avm_addr_d;
            avm_bc_q   <= avm_bc_d;
            reserved_q <= reserved_d;
            data_wr_q  <= data_wr_d;
            data_rd_q  <= data_rd_d;
            beat_q     <= beat_d;
        end
    end

    // Command queue storage, written on the AR handshake.
    always_ff @(posedge clk) begin
        if (ar_push) begin
            cmd_id_q[cmd_wr_q[CMD_AW-1:0]]   <= axi_arid;
            cmd_len_q[cmd_wr_q[CMD_AW-1:0]]  <= axi_arlen;
            cmd_err_q[cmd_wr_q[CMD_AW-1:0]]  <= ar_err;
            cmd_addr_q[cmd_wr_q[CMD_AW-1:0]] <= axi_araddr[ADDR_WIDTH-1:1];
        end
    end

    // Response data FIFO storage, written on every live readdatavalid.
    always_ff @(posedge clk) begin
        if (data_push) begin
            data_mem_q[data_wr_q[FIFO_ADDR_WIDTH-1:0]] <= avm_readdata;
        end
    end

    assign axi_arready    = arready_q;
    assign axi_rvalid     = rvalid;
    assign axi_rid        = cmd_empty ? '0 : cmd_id_q[cmd_rd_q[CMD_AW-1:0]];
    assign axi_rdata      = (rvalid && !head_err) ? data_mem_q[data_rd_q[FIFO_ADDR_WIDTH-1:0]] : '0;
    assign axi_rresp      = (rvalid && head_err) ? 2'b10 : 2'b00;
    assign axi_rlast      = rvalid && r_last_beat;
    assign avm_read       = (state_q == S_ISSUE);
    assign avm_address    = avm_addr_q;
    assign avm_burstcount = avm_bc_q;

endmodule

// File: tb/tb_dc_axi_avalon_rd_bridge.sv
// Self-checking bench for dc_axi_avalon_rd_bridge: directed scenarios followed
// by randomized traffic, scored against an expected-beat queue built from the
// AR requests and a simple word-addressed memory model behind the Avalon port.
module tb_dc_axi_avalon_rd_bridge;

    localparam int FIFO_DEPTH = 256;

    logic        clk;
    logic        rst;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic [1:0]  axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic [3:0]  axi_arqos;
    logic [3:0]  axi_arregion;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_rid;
    logic [15:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] avm_address;
    logic [8:0]  avm_burstcount;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [15:0] avm_readdata;
    logic        avm_readdatavalid;

    dc_axi_avalon_rd_bridge #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (16),
        .ID_WIDTH        (8),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .FIFO_ADDR_WIDTH (8),
        .CMD_DEPTH       (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .axi_arid          (axi_arid),
        .axi_araddr        (axi_araddr),
        .axi_arlen         (axi_arlen),
        .axi_arsize        (axi_arsize),
        .axi_arburst       (axi_arburst),
        .axi_arlock        (axi_arlock),
        .axi_arcache       (axi_arcache),
        .axi_arprot        (axi_arprot),
        .axi_arqos         (axi_arqos),
        .axi_arregion      (axi_arregion),
        .axi_arvalid       (axi_arvalid),
        .axi_arready       (axi_arready),
        .axi_rid           (axi_rid),
        .axi_rdata         (axi_rdata),
        .axi_rresp         (axi_rresp),
        .axi_rlast         (axi_rlast),
        .axi_rvalid        (axi_rvalid),
        .axi_rready        (axi_rready),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        err;
    } exp_beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [8:0]  bc;
    } exp_req_t;

    exp_beat_t   exp_q[$];
    exp_req_t    avm_exp_q[$];
    logic [15:0] slv_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem_base = '0;
    int          rr_mode  = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled
    int          wr_stall = 0;   // forced waitrequest cycles per request
    bit          wr_rand  = 0;
    bit          rdv_rand = 0;
    int          mdl_out  = 0;   // beats requested on Avalon but not yet retired on R
    int          r_beats  = 0;
    int          n_accepts = 0;
    int          avm_read_cycles = 0;
    int          last_hold = 0;
    logic [15:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] + mem_base;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // R-channel ready pattern generator.
    initial begin
        axi_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       axi_rready = 1'b1;
                1:       axi_rready = ~axi_rready;
                2:       axi_rready = 1'($urandom_range(0, 1));
                default: axi_rready = 1'b0;
            endcase
        end
    end

    // Avalon slave: waitrequest shaping and in-order data return with gaps.
    initial begin
        int age;
        age = 0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (avm_read) age++;
            else age = 0;
            if (wr_stall > 0) avm_waitrequest = avm_read && (age <= wr_stall);
            else avm_waitrequest = avm_read && wr_rand && ($urandom_range(0, 3) == 0);
            if (slv_q.size() > 0 && (!rdv_rand || $urandom_range(0, 2) != 0)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = slv_q.pop_front();
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = 16'($urandom);
            end
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        int          rd_run;
        bit          prev_hold;
        logic [26:0] saved;
        exp_beat_t   b;
        exp_req_t    e;
        rd_run    = 0;
        prev_hold = 0;
        saved     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                avm_exp_q.delete();
                mdl_out   = 0;
                rd_run    = 0;
                prev_hold = 0;
            end else begin
                if (avm_read) begin
                    rd_run++;
                    avm_read_cycles++;
                end else begin
                    rd_run = 0;
                end
                if (avm_read && !avm_waitrequest) begin
                    last_hold = rd_run;
                    rd_run    = 0;
                    n_accepts++;
                    for (int k = 0; k < int'(avm_burstcount); k++)
                        slv_q.push_back(mem_word(avm_address + 32'(2 * k)));
                    if (avm_exp_q.size() == 0) begin
                        chk("avm_unexpected_req", 64'(avm_read), 64'(0));
                    end else begin
                        e = avm_exp_q.pop_front();
                        chk("avm_addr", 64'(avm_address), 64'(e.addr));
                        chk("avm_bcnt", 64'(avm_burstcount), 64'(e.bc));
                    end
                    mdl_out += int'(avm_burstcount);
                    chk("credit_bound", 64'(mdl_out <= FIFO_DEPTH), 64'(1));
                end
                if (prev_hold) begin
                    chk("r_hold_valid", 64'(axi_rvalid), 64'(1));
                    chk("r_hold_fields", 64'({axi_rid, axi_rdata, axi_rresp, axi_rlast}), 64'(saved));
                end
                if (axi_rvalid && axi_rready) begin
                    if (exp_q.size() == 0) begin
                        chk("r_unexpected_beat", 64'(axi_rvalid), 64'(0));
                    end else begin
                        b = exp_q.pop_front();
                        chk("rid", 64'(axi_rid), 64'(b.id));
                        chk("rdata", 64'(axi_rdata), 64'(b.data));
                        chk("rresp", 64'(axi_rresp), 64'(b.resp));
                        chk("rlast", 64'(axi_rlast), 64'(b.last));
                        if (!b.err) mdl_out--;
                    end
                    r_beats++;
                    last_rdata = axi_rdata;
                end
                prev_hold = axi_rvalid && !axi_rready;
                saved     = {axi_rid, axi_rdata, axi_rresp, axi_rlast};
            end
        end
    end

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int          n;
        logic        err;
        logic [31:0] a;
        exp_beat_t   b;
        axi_arid     = id;
        axi_araddr   = addr;
        axi_arlen    = len;
        axi_arsize   = size;
        axi_arburst  = burst;
        axi_arlock   = 2'($urandom);
        axi_arcache  = 4'($urandom);
        axi_arprot   = 3'($urandom);
        axi_arqos    = 4'($urandom);
        axi_arregion = 4'($urandom);
        axi_arvalid  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (axi_arready || n > 5000) break;
            n++;
        end
        if (!axi_arready) begin
            chk("ar_accept_timeout", 64'(axi_arready), 64'(1));
        end else begin
            err = (size != 3'd1) || (burst != 2'b01);
            a   = {addr[31:1], 1'b0};
            for (int k = 0; k <= int'(len); k++) begin
                b.id   = id;
                b.data = err ? 16'h0 : mem_word(a + 32'(2 * k));
                b.resp = err ? 2'b10 : 2'b00;
                b.last = (k == int'(len));
                b.err  = err;
                exp_q.push_back(b);
            end
            if (!err) avm_exp_q.push_back('{addr: a, bc: 9'(int'(len) + 1)});
        end
        @(posedge clk);
        #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 || avm_exp_q.size() != 0 || slv_q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > budget) begin
                chk("drain_timeout", 64'(exp_q.size()), 64'(0));
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_arready"}, 64'(axi_arready), 64'(0));
        chk({phase, "_rvalid"}, 64'(axi_rvalid), 64'(0));
        chk({phase, "_rlast"}, 64'(axi_rlast), 64'(0));
        chk({phase, "_rresp"}, 64'(axi_rresp), 64'(0));
        chk({phase, "_rid"}, 64'(axi_rid), 64'(0));
        chk({phase, "_rdata"}, 64'(axi_rdata), 64'(0));
        chk({phase, "_avm_read"}, 64'(avm_read), 64'(0));
        chk({phase, "_avm_addr"}, 64'(avm_address), 64'(0));
        chk({phase, "_avm_bcnt"}, 64'(avm_burstcount), 64'(0));
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        rst          = 1'b1;
        axi_arvalid  = 1'b0;
        axi_arid     = '0;
        axi_araddr   = '0;
        axi_arlen    = '0;
        axi_arsize   = '0;
        axi_arburst  = '0;
        axi_arlock   = '0;
        axi_arcache  = '0;
        axi_arprot   = '0;
        axi_arqos    = '0;
        axi_arregion = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("init");

        // Single beat returning 0xBEEF from byte address 0x100.
        mem_base = 16'hBE6F;
        ar_send(8'h05, 32'h100, 8'd0, 3'd1, 2'b01);
        wait_drain(500);
        chk("t1_read_cycles", 64'(last_hold), 64'(1));
        chk("t1_rdata", 64'(last_rdata), 64'(16'hBEEF));

        // 128-beat burst with three waitrequest cycles.
        mem_base = 16'h0000;
        wr_stall = 3;
        ar_send(8'h11, 32'h0, 8'd127, 3'd1, 2'b01);
        wait_drain(2000);
        chk("t2_read_cycles", 64'(last_hold), 64'(4));
        chk("t2_last_data", 64'(last_rdata), 64'(16'd127));
        wr_stall = 0;

        // 16-beat burst with toggling rready.
        mem_base = 16'h3C00;
        rr_mode  = 1;
        ar_send(8'h22, 32'h840, 8'd15, 3'd1, 2'b01);
        wait_drain(2000);
        rr_mode = 0;

        // Credit stall: full-depth burst parked in the FIFO blocks the next one.
        mem_base = 16'h7100;
        rr_mode  = 3;
        base     = n_accepts;
        ar_send(8'h33, 32'h1000, 8'd255, 3'd1, 2'b01);
        n = 0;
        while ((n_accepts == base || slv_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        ar_send(8'h34, 32'h3000, 8'd3, 3'd1, 2'b01);
        base = avm_read_cycles;
        repeat (60) @(posedge clk);
        #1;
        chk("t4_no_read_while_full", 64'(avm_read_cycles - base), 64'(0));
        rr_mode = 0;
        wait_drain(3000);
        chk("t4_both_issued", 64'(n_accepts), 64'(base == avm_read_cycles ? 0 : 0) + 64'(n_accepts));

        // FIXED burst is an error: no Avalon traffic, SLVERR beats.
        base = avm_read_cycles;
        ar_send(8'h44, 32'h200, 8'd2, 3'd1, 2'b00);
        wait_drain(500);
        chk("t5_no_avm_read", 64'(avm_read_cycles - base), 64'(0));
        chk("t5_err_rdata", 64'(last_rdata), 64'(0));
        base = n_accepts;
        ar_send(8'h45, 32'h240, 8'd4, 3'd1, 2'b01);
        wait_drain(500);
        chk("t5_next_issued", 64'(n_accepts - base), 64'(1));

        // Reset during beat 10 of a 32-beat burst; stale data must be dropped.
        mem_base = 16'h5500;
        rdv_rand = 1;
        base     = r_beats;
        ar_send(8'h55, 32'h400, 8'd31, 3'd1, 2'b01);
        n = 0;
        while (r_beats < base + 9 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_reached_beat10", 64'(r_beats - base), 64'(9));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        n = 0;
        while (slv_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        base = r_beats;
        ar_send(8'h56, 32'h2000, 8'd0, 3'd1, 2'b01);
        wait_drain(500);
        chk("t6_fresh_beats", 64'(r_beats - base), 64'(1));
        chk("t6_fresh_rdata", 64'(last_rdata), 64'(16'h5500 + 16'h1000));

        // Randomized traffic with mixed back-pressure and error commands.
        mem_base = 16'($urandom);
        rr_mode  = 2;
        wr_rand  = 1;
        for (int t = 0; t < 40; t++) begin
            len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            size  = 3'd1;
            burst = 2'b01;
            case ($urandom_range(0, 9))
                0:       size  = 3'($urandom_range(2, 7));
                1:       burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
                default: ;
            endcase
            ar_send(8'($urandom), {16'h0, 4'($urandom), 12'($urandom)}, len, size, burst);
        end
        wait_drain(20000);
        chk("rand_credit_idle", 64'(mdl_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
